// File: rtl/noc_pkg.sv
// Shared router constants: port count, crossbar select encoding and port indices.
package noc_pkg;
   localparam int unsigned NUM_PORTS  = 5;
   localparam int unsigned SEL_W      = 3;
   localparam logic [SEL_W-1:0] SEL_IDLE = 3'b111;

   localparam int unsigned PORT_LOCAL = 0;
   localparam int unsigned PORT_N     = 1;
   localparam int unsigned PORT_E     = 2;
   localparam int unsigned PORT_S     = 3;
   localparam int unsigned PORT_W     = 4;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_LOCKED = 1'b1
   } arb_state_e;
endpackage

// File: rtl/rr_pick5.sv
// Combinational round-robin picker: first requester at ptr+1, ptr+2, ... modulo NUM_PORTS.
module rr_pick5
   import noc_pkg::*;
(
   input  logic [NUM_PORTS-1:0] req,
   input  logic [SEL_W-1:0]     ptr,
   output logic [SEL_W-1:0]     winner,
   output logic                 any
);

   logic [SEL_W-1:0] idx;

   always_comb begin
      winner = SEL_IDLE;
      any    = 1'b0;
      idx    = '0;
      for (int unsigned k = 1; k <= NUM_PORTS; k++) begin
         idx = SEL_W'((32'(ptr) + k) % NUM_PORTS);
         if (!any && req[idx]) begin
            any    = 1'b1;
            winner = idx;
         end
      end
   end

endmodule

// File: rtl/xbar_out_arbiter.sv
// Per-output switch arbiter: round-robin grant held as a wormhole lock until the owner's tail flit transfers.
module xbar_out_arbiter
   import noc_pkg::*;
(
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [NUM_PORTS-1:0] req,
   input  logic [NUM_PORTS-1:0] flit_valid,
   input  logic [NUM_PORTS-1:0] flit_tail,
   input  logic                 out_ready,
   output logic [NUM_PORTS-1:0] grant,
   output logic [SEL_W-1:0]     sel,
   output logic                 locked,
   output logic                 fire
);

   arb_state_e           state_q, state_d;
   logic [SEL_W-1:0]     ptr_q, ptr_d;
   logic [NUM_PORTS-1:0] grant_q, grant_d;
   logic [SEL_W-1:0]     sel_q, sel_d;
   logic                 locked_q, locked_d;

   logic [SEL_W-1:0]     pick_winner;
   logic                 pick_any;
   logic                 tail_sel;

   rr_pick5 u_pick (
      .req    (req),
      .ptr    (ptr_q),
      .winner (pick_winner),
      .any    (pick_any)
   );

   // grant_q is one-hot while locked, so masking selects the owner's flit signals.
   assign fire     = locked_q & (|(flit_valid & grant_q)) & out_ready;
   assign tail_sel = |(flit_tail & grant_q);

   always_comb begin
      state_d  = state_q;
      ptr_d    = ptr_q;
      grant_d  = grant_q;
      sel_d    = sel_q;
      locked_d = locked_q;
      case (state_q)
         ST_IDLE: begin
            if (pick_any) begin
               state_d  = ST_LOCKED;
               ptr_d    = pick_winner;
               grant_d  = NUM_PORTS'(1) << pick_winner;
               sel_d    = pick_winner;
               locked_d = 1'b1;
            end
         end
         ST_LOCKED: begin
            if (fire && tail_sel) begin
               state_d  = ST_IDLE;
               grant_d  = '0;
               sel_d    = SEL_IDLE;
               locked_d = 1'b0;
            end
         end
         default: begin
            state_d  = ST_IDLE;
            grant_d  = '0;
            sel_d    = SEL_IDLE;
            locked_d = 1'b0;
         end
      endcase
   end

   // Reset leaves port 0 with first priority.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         ptr_q    <= SEL_W'(PORT_W);
         grant_q  <= '0;
         sel_q    <= SEL_IDLE;
         locked_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ptr_q    <= ptr_d;
         grant_q  <= grant_d;
         sel_q    <= sel_d;
         locked_q <= locked_d;
      end
   end

   assign grant  = grant_q;
   assign sel    = sel_q;
   assign locked = locked_q;

endmodule

// File: tb/tb_xbar_out_arbiter.sv
// Randomized and directed bench for xbar_out_arbiter against an owner/pointer reference model.
module tb_xbar_out_arbiter;

   logic       clk;
   logic       rst_n;
   logic [4:0] req;
   logic [4:0] flit_valid;
   logic [4:0] flit_tail;
   logic       out_ready;
   logic [4:0] grant;
   logic [2:0] sel;
   logic       locked;
   logic       fire;

   int n_checks;
   int n_errors;

   // Reference model: who owns the output (-1 = nobody) and last winner.
   int owner;
   int mptr;
   int order_q[$];

   xbar_out_arbiter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .req        (req),
      .flit_valid (flit_valid),
      .flit_tail  (flit_tail),
      .out_ready  (out_ready),
      .grant      (grant),
      .sel        (sel),
      .locked     (locked),
      .fire       (fire)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic check_outputs(input logic [4:0] v, input logic o);
      logic [4:0] exp_grant;
      logic [2:0] exp_sel;
      logic       exp_fire;
      exp_grant = (owner >= 0) ? 5'(1 << owner) : 5'b00000;
      exp_sel   = (owner >= 0) ? 3'(owner) : 3'b111;
      exp_fire  = (owner >= 0) && v[owner] && o;
      check_eq("grant", 32'(grant), 32'(exp_grant));
      check_eq("sel", 32'(sel), 32'(exp_sel));
      check_eq("locked", 32'(locked), 32'(owner >= 0));
      check_eq("fire", 32'(fire), 32'(exp_fire));
      check_eq("sel_legal", 32'(sel == 3'b101 || sel == 3'b110), 32'(0));
   endtask

   // One cycle: drive at negedge, check, advance model, wait for next negedge.
   task automatic step(input logic [4:0] r, input logic [4:0] v, input logic [4:0] t, input logic o);
      req        = r;
      flit_valid = v;
      flit_tail  = t;
      out_ready  = o;
      #1;
      check_outputs(v, o);
      if (owner >= 0) order_q.push_back(owner);
      if (owner < 0) begin
         if (r != 5'b0) begin
            for (int k = 1; k <= 5; k++) begin
               int p;
               p = (mptr + k) % 5;
               if (owner < 0 && r[p]) begin
                  owner = p;
                  mptr  = p;
               end
            end
         end
      end else if (v[owner] && o && t[owner]) begin
         owner = -1;
      end
      @(negedge clk);
   endtask

   task automatic do_reset();
      #2 rst_n = 1'b0;
      #1;
      owner = -1;
      mptr  = 4;
      check_eq("rst_grant", 32'(grant), 32'(0));
      check_eq("rst_sel", 32'(sel), 32'(3'b111));
      check_eq("rst_locked", 32'(locked), 32'(0));
      check_eq("rst_fire", 32'(fire), 32'(0));
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      int exp_order[6];
      logic [4:0] r, v, t;
      logic       o;
      exp_order = '{0, 1, 2, 3, 4, 0};
      n_checks = 0;
      n_errors = 0;
      rst_n = 1'b0;
      req = '0; flit_valid = '0; flit_tail = '0; out_ready = 1'b0;
      owner = -1;
      mptr  = 4;
      @(negedge clk);
      check_eq("por_grant", 32'(grant), 32'(0));
      check_eq("por_sel", 32'(sel), 32'(3'b111));
      check_eq("por_locked", 32'(locked), 32'(0));
      rst_n = 1'b1;
      @(negedge clk);

      // Single request, 3-flit packet, then bubble.
      step(5'b00100, 5'b00000, 5'b00000, 1'b1);
      check_eq("s1_grant", 32'(grant), 32'(5'b00100));
      check_eq("s1_sel", 32'(sel), 32'(3'b010));
      step(5'b00000, 5'b00100, 5'b00000, 1'b1);
      step(5'b00000, 5'b00100, 5'b00000, 1'b1);
      step(5'b00000, 5'b00100, 5'b00100, 1'b1);
      check_eq("s1_bubble_sel", 32'(sel), 32'(3'b111));
      step(5'b00000, 5'b00000, 5'b00000, 1'b1);

      // Fairness from reset with all ports requesting single-flit packets.
      do_reset();
      order_q.delete();
      for (int i = 0; i < 12; i++) step(5'b11111, 5'b11111, 5'b11111, 1'b1);
      for (int i = 0; i < 6; i++)
         check_eq("rr_order", 32'((i < order_q.size()) ? order_q[i] : -1), 32'(exp_order[i]));
      step(5'b00000, 5'b11111, 5'b11111, 1'b1);

      // Backpressure on port 3.
      step(5'b01000, 5'b00000, 5'b00000, 1'b1);
      step(5'b00000, 5'b01000, 5'b00000, 1'b1);
      for (int i = 0; i < 4; i++) step(5'b01000, 5'b01000, 5'b01000, 1'b0);
      check_eq("bp_sel", 32'(sel), 32'(3'b011));
      step(5'b00000, 5'b01000, 5'b01000, 1'b1);
      check_eq("bp_released", 32'(locked), 32'(0));
      step(5'b00000, 5'b00000, 5'b00000, 1'b1);

      // Lock integrity: port 1 keeps the output despite port 0 activity.
      step(5'b00010, 5'b00000, 5'b00000, 1'b1);
      for (int i = 0; i < 3; i++) step(5'b00001, 5'b00011, 5'b00001, 1'b1);
      check_eq("lock_grant", 32'(grant), 32'(5'b00010));
      step(5'b00001, 5'b00011, 5'b00011, 1'b1);
      step(5'b00001, 5'b00001, 5'b00001, 1'b0);
      check_eq("lock_next", 32'(grant), 32'(5'b00001));
      step(5'b00000, 5'b00001, 5'b00001, 1'b1);

      // Reset while port 4 owns the output.
      step(5'b10000, 5'b00000, 5'b00000, 1'b1);
      step(5'b10000, 5'b10000, 5'b00000, 1'b1);
      check_eq("pre_rst_grant", 32'(grant), 32'(5'b10000));
      do_reset();
      step(5'b10001, 5'b00000, 5'b00000, 1'b0);
      check_eq("post_rst_grant", 32'(grant), 32'(5'b00001));
      step(5'b00000, 5'b00001, 5'b00001, 1'b1);

      // Idle: no requests, random flit noise.
      for (int i = 0; i < 10; i++) step(5'b00000, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1'b1);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         r = ($urandom_range(0, 3) == 0) ? 5'b0 : 5'($urandom_range(0, 31));
         v = 5'($urandom_range(0, 31));
         t = 5'($urandom_range(0, 31)) & 5'($urandom_range(0, 31));
         o = ($urandom_range(0, 3) != 0);
         step(r, v, t, o);
         if (i == 1500) do_reset();
      end

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1);
   end

endmodule

// File: doc/xbar_out_arbiter.md
# xbar_out_arbiter

Per-output-port switch arbiter for the 5-port router. It sits directly upstream of the 5:1 crossbar output mux, and its registered `sel` drives that mux's 3-bit control. It grants one input port at a time using round-robin priority. The grant is held (wormhole lock) until the granted port's tail flit has been transferred downstream.

## Interface
Parameters:
- `NUM_PORTS`, 5, number of router input ports (local, N, E, S, W = indices 0..4)
- `SEL_W`, 3, width of the mux select
- `SEL_IDLE`, 3'b111, select value driven when no port is granted (mux output is tri-stated)

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock, rising edge
- `rst_n`  in  1  asynchronous active-low reset
- `req`  in  NUM_PORTS  input port i has a head flit routed to this output
- `flit_valid`  in  NUM_PORTS  input port i presents a valid flit this cycle
- `flit_tail`  in  NUM_PORTS  flit presented by port i is a tail (a single-flit packet is both head and tail)
- `out_ready`  in  1  downstream accepts a flit this cycle
- `grant`  out  NUM_PORTS  one-hot registered grant; 0 when idle
- `sel`  out  SEL_W  registered crossbar mux control: binary index of the granted port, or SEL_IDLE
- `locked`  out  1  an input port currently owns this output
- `fire`  out  1  combinational; a flit transfers this cycle

## Operation
- FSM states and transitions:
  - IDLE: `locked`=0, `grant`=0, `sel`=SEL_IDLE.
    - If `req` is nonzero, pick a winner by round-robin and go to LOCKED.
    - Winner search order is ptr+1, ptr+2, … mod 5.
    - On the grant edge, set `ptr` to the winner.
  - LOCKED: `grant`=onehot(winner), `sel`=winner, `locked`=1.
    - `fire` = locked & flit_valid[sel] & out_ready.
    - On fire with flit_tail[sel]=1: return to IDLE at that edge; `ptr` is unchanged.
    - On fire without tail: stay in LOCKED.
- `req` changes while LOCKED are ignored, including withdrawal by the owner. The lock is released only by a tail fire.
- `flit_valid`/`flit_tail` of non-granted ports are ignored.
- `fire` is 0 in IDLE.
- `sel` never takes values 3'b101 or 3'b110.
- The `grant` and `sel` registers are updated together, so they always agree.

## Timing
- Reset (asynchronous assert, synchronous deassert expected upstream):
  - state=IDLE, `grant`=5'b00000, `sel`=3'b111, `locked`=0, `ptr`=4.
  - With ptr=4, port 0 has first priority after reset.
- Arbitration latency is 1 cycle. A `req` sampled in IDLE at edge N makes `grant`/`sel` valid from edge N onward, so the first fire is possible in the cycle after edge N.
- Release: a tail fire in cycle K returns the FSM to IDLE at edge K. Cycle K+1 is IDLE with `sel`=SEL_IDLE, and re-arbitration happens at edge K+1. This leaves a one-cycle bubble between packets.
- A single-flit packet holds the lock for at least 1 cycle: one grant cycle, with fire in the same cycle if `flit_valid` and `out_ready` are both high.
- Backpressure: `out_ready`=0 stalls with no state change. The lock is held indefinitely.
- Reset asserted mid-packet: the lock is dropped immediately and all outputs return to their reset values. Upstream buffers are responsible for packet recovery.

## Structure
- Shared package `noc_pkg`: NUM_PORTS, SEL_W, SEL_IDLE, and port index constants (PORT_LOCAL=0, PORT_N=1, PORT_E=2, PORT_S=3, PORT_W=4).
- Sub-module `rr_pick5`: purely combinational. Inputs are `req[4:0]` and `ptr[2:0]`; outputs are `winner[2:0]` and `any`.
- The top level holds the FSM, the `ptr`/`grant`/`sel` registers, and the `fire` logic.

## Test plan
- Reset then single request:
  - Stimulus: `req`=5'b00100.
  - Required response: next cycle `grant`=5'b00100, `sel`=3'b010, `locked`=1. A 3-flit packet with the tail on the 3rd valid flit, and `out_ready`=1, gives fire for exactly 3 cycles, then `sel`=3'b111 for 1 cycle.
- Round-robin fairness:
  - Stimulus: `req`=5'b11111 held, single-flit packets.
  - Required response: grant order after reset is 0,1,2,3,4,0. Each packet takes 2 cycles (grant/fire + bubble).
- Backpressure:
  - Stimulus: granted port 3, `out_ready`=0 for 4 cycles mid-packet.
  - Required response: `sel`=3'b011 and `locked`=1 held, `fire`=0, no release. The tail fire after `out_ready` returns to 1 releases the lock.
- Lock integrity:
  - Stimulus: while port 1 is locked, drop `req[1]` and raise `req[0]` and `flit_valid[0]`.
  - Required response: `grant` stays 5'b00010 until the port 1 tail fires, then port 0 is granted.
- Reset mid-packet:
  - Stimulus: assert `rst_n`=0 while port 4 is locked.
  - Required response: `grant`, `sel` and `locked` go to 0, 3'b111 and 0 asynchronously. After release, `req`=5'b10001 grants port 0 first.
- Idle select check:
  - Stimulus: `req`=0 for 10 cycles.
  - Required response: `sel`=3'b111 and `fire`=0 throughout; `sel` is never 3'b101 or 3'b110 in any scenario.
